s64x7_fetch_queue: RTL

- Parametrised instruction-packet prefetcher for the S64X7 core.
- Acts as the core's instruction-side bus master:
  - issues 64-bit Wishbone-style read cycles with vpa_o=1;
  - buffers up to DEPTH packets;
  - hands packets to the opcode sequencer over a valid/ready handshake.
- Generalises the single-packet fetch of the current core. Adds configurable depth, a configurable reset vector, flush-on-branch and bus yield to the data side.

---
 rtl/s64x7_pkg.sv | 22 ++
 rtl/s64x7_pkt_fifo.sv | 76 +++++++
 rtl/s64x7_fetch_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/s64x7_pkg.sv
// s64x7_pkg: shared widths, FSM encoding and packet entry layout for the
// S64X7 instruction fetch queue.
package s64x7_pkg;

    localparam int ADR_W = 61;   // bus address bits [63:3]
    localparam int PKT_W = 64;   // one instruction packet

    localparam logic [7:0] SEL_ALL = 8'hFF;

    // Fetch FSM: IDLE = no bus cycle, FETCH = read cycle outstanding.
    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_e;

    // One buffered packet: address in the upper bits, data in the lower bits.
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [PKT_W-1:0] data;
    } pkt_entry_t;

endpackage

// File: rtl/s64x7_pkt_fifo.sv
// s64x7_pkt_fifo: DEPTH-entry synchronous packet FIFO with a synchronous
// clear and an occupancy count. The head entry is read straight out of the
// storage registers, so it is stable while valid and not popped.
module s64x7_pkt_fifo
    import s64x7_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  pkt_entry_t       wdata_i,
    output pkt_entry_t       rdata_o,
    output logic             valid_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    pkt_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // Next pointers and count; clear beats push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet storage; contents need no reset because count gates validity.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/s64x7_fetch_queue.sv
// s64x7_fetch_queue: instruction-side bus master and packet prefetcher for
// the S64X7 core. Issues 64-bit read cycles (vpa_o=1), buffers up to DEPTH
// packets and presents them to the sequencer over valid/ready.
//
// Handshake: a packet transfers on a rising edge where pkt_valid_o and
// pkt_ready_i are both 1; pkt_o/pkt_adr_o hold steady until that edge.
//
// Optional feature macro: S64X7_FETCH_ERR_EN adds err_i/fault_o (bus error
// ends the cycle without a push and halts fetch until flush or reset).
module s64x7_fetch_queue
    import s64x7_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [63:0] RESET_VECTOR = 64'hE000_0000_0000_0000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic [ADR_W-1:0]  adr_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [7:0]        sel_o,
    output logic              we_o,
    output logic              vpa_o,
    input  logic              ack_i,
    input  logic [PKT_W-1:0]  dat_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [ADR_W-1:0]  target_i,
`ifdef S64X7_FETCH_ERR_EN
    input  logic              err_i,
    output logic              fault_o,
`endif
    output logic              pkt_valid_o,
    output logic [PKT_W-1:0]  pkt_o,
    output logic [ADR_W-1:0]  pkt_adr_o,
    input  logic              pkt_ready_i
);

    // FIFO pointer width, derived from DEPTH (at least one bit).
    localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [ADR_W-1:0] pc_q, pc_d;
    logic             fault_q, fault_d;
    logic             err_w;

    logic             push;
    logic             pop;
    logic             clear;
    logic             fifo_valid;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   cnt_after_push;
    pkt_entry_t       wentry;
    pkt_entry_t       head;

`ifdef S64X7_FETCH_ERR_EN
    assign err_w   = err_i;
    assign fault_o = fault_q;
`else
    assign err_w   = 1'b0;
`endif

    // Occupancy after an ack-driven push in this cycle, net of any pop.
    assign cnt_after_push = count + (PTR_W + 1)'(1) - (PTR_W + 1)'(pop);

    // Fetch FSM, PC update and FIFO control. Flush overrides everything
    // except reset; the issue rule keeps the FIFO from overflowing.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        clear   = 1'b0;
        pop     = fifo_valid & pkt_ready_i;
        if (flush_i) begin
            clear   = 1'b1;
            pop     = 1'b0;
            state_d = IDLE;
            pc_d    = target_i;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hold_i && !fault_q && (count < DEPTH_C)) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (err_w) begin
                        // Bus error: end the cycle, keep PC at the fault.
                        state_d = IDLE;
                        fault_d = 1'b1;
                    end else if (ack_i) begin
                        push = 1'b1;
                        pc_d = pc_q + 1'b1;
                        if (!hold_i && (cnt_after_push < DEPTH_C)) begin
                            state_d = FETCH;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, PC and fault registers; reset starts a fetch at RESET_VECTOR.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_VECTOR[63:3];
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign wentry = '{adr: pc_q, data: dat_i};

    s64x7_pkt_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .valid_o (fifo_valid),
        .count_o (count)
    );

    // Bus side: the PC register doubles as the address of the open cycle.
    assign cyc_o = (state_q == FETCH);
    assign stb_o = cyc_o;
    assign vpa_o = cyc_o;
    assign adr_o = pc_q;
    assign sel_o = SEL_ALL;
    assign we_o  = 1'b0;

    // Sequencer side.
    assign pkt_valid_o = fifo_valid;
    assign pkt_o       = head.data;
    assign pkt_adr_o   = head.adr;

endmodule
